// File: rtl/simple_proc_datapath_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, FSM states, widths.
package simple_proc_datapath_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG       = 4;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/simple_proc_datapath_en_reg.sv
// Load-enable register with asynchronous clear; used for R0..R3, A and G.
module en_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d on the rising edge when enabled; reset clears the contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/simple_proc_datapath.sv
// Multi-cycle datapath: four general registers, accumulator A, result G,
// add/sub ALU and an AND-OR shared bus sequenced by a four-state FSM.
module simple_proc_datapath
    import simple_proc_datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [5:0]        instr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] bus,
    output logic              done,
    output logic [DATA_W-1:0] r0_q,
    output logic [DATA_W-1:0] r1_q,
    output logic [DATA_W-1:0] r2_q,
    output logic [DATA_W-1:0] r3_q
);

    state_t            state_q, state_d;
    logic [5:0]        ir_q;
    logic              irLoad;
    logic [1:0]        op, rx, ry;

    logic [DATA_W-1:0] regQ [NREG];
    logic [NREG-1:0]   regLoad;
    logic              rxLoad;
    logic              aLoad, gLoad;
    logic [DATA_W-1:0] a_q, g_q, aluOut;

    logic              drvRy, drvRx, drvDin, drvG;

    assign op = ir_q[5:4];
    assign rx = ir_q[3:2];
    assign ry = ir_q[1:0];

    // State register; reset aborts any instruction in flight and returns to T0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register; only written when an instruction is accepted in T0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else if (irLoad) begin
            ir_q <= instr;
        end
    end

    // Control: next state, one-hot bus driver enables, register loads and done.
    always_comb begin
        state_d = state_q;
        irLoad  = 1'b0;
        drvRy   = 1'b0;
        drvRx   = 1'b0;
        drvDin  = 1'b0;
        drvG    = 1'b0;
        rxLoad  = 1'b0;
        aLoad   = 1'b0;
        gLoad   = 1'b0;
        done    = 1'b0;
        case (state_q)
            T0: begin
                if (run) begin
                    irLoad  = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        drvRy   = 1'b1;
                        rxLoad  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        drvDin  = 1'b1;
                        rxLoad  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    default: begin
                        drvRx   = 1'b1;
                        aLoad   = 1'b1;
                        state_d = T2;
                    end
                endcase
            end
            T2: begin
                drvRy   = 1'b1;
                gLoad   = 1'b1;
                state_d = T3;
            end
            T3: begin
                drvG    = 1'b1;
                rxLoad  = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    // Decode the Rx index into a per-register load enable.
    always_comb begin
        regLoad = '0;
        for (int i = 0; i < NREG; i++) begin
            regLoad[i] = rxLoad && (rx == 2'(i));
        end
    end

    // AND-OR shared bus: with no driver enabled the bus reads zero.
    always_comb begin
        bus = ({DATA_W{drvRy}}  & regQ[ry])
            | ({DATA_W{drvRx}}  & regQ[rx])
            | ({DATA_W{drvDin}} & din)
            | ({DATA_W{drvG}}   & g_q);
    end

    // ALU: A plus or minus the bus, modulo 2^DATA_W.
    always_comb begin
        aluOut = (op == OP_SUB) ? (a_q - bus) : (a_q + bus);
    end

    for (genvar i = 0; i < NREG; i++) begin : gen_regs
        en_reg #(.W(DATA_W)) uReg (
            .clk (clk),
            .rst (rst),
            .en  (regLoad[i]),
            .d   (bus),
            .q   (regQ[i])
        );
    end

    en_reg #(.W(DATA_W)) uRegA (
        .clk (clk),
        .rst (rst),
        .en  (aLoad),
        .d   (bus),
        .q   (a_q)
    );

    en_reg #(.W(DATA_W)) uRegG (
        .clk (clk),
        .rst (rst),
        .en  (gLoad),
        .d   (aluOut),
        .q   (g_q)
    );

    assign r0_q = regQ[0];
    assign r1_q = regQ[1];
    assign r2_q = regQ[2];
    assign r3_q = regQ[3];

endmodule

// File: tb/tb_simple_proc_datapath.sv
// Bench for simple_proc_datapath: table of instructions checked against a
// register-file model and scoreboard, plus reset and mid-instruction reset.
module tb_simple_proc_datapath;
    import simple_proc_datapath_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic [5:0]   instr = '0;
    logic [W-1:0] din = '0;
    logic [W-1:0] bus;
    logic         done;
    logic [W-1:0] r0_q, r1_q, r2_q, r3_q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] op;
        logic [1:0] rx;
        logic [1:0] ry;
        logic [W-1:0] d;
        logic [W-1:0] expVal;
        bit noise;
    } vec_t;

    typedef struct {
        logic [1:0] rx;
        logic [W-1:0] val;
        int lat;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
        logic [W-1:0] b2;
    } sb_t;

    sb_t          sbQ[$];
    logic [W-1:0] model[4];
    logic [W-1:0] busLog[$];
    int           latency;
    bit           sawDone;
    vec_t         vecs[15];

    simple_proc_datapath #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .instr (instr),
        .din   (din),
        .bus   (bus),
        .done  (done),
        .r0_q  (r0_q),
        .r1_q  (r1_q),
        .r2_q  (r2_q),
        .r3_q  (r3_q)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [W-1:0] getReg(input logic [1:0] idx);
        case (idx)
            2'd0:    return r0_q;
            2'd1:    return r1_q;
            2'd2:    return r2_q;
            default: return r3_q;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction from T0 and follow it until done (bounded).
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        e.rx = v.rx;
        e.b0 = '0;
        e.b1 = '0;
        e.b2 = '0;
        case (v.op)
            OP_MV:  begin e.val = model[v.ry]; e.lat = 1; e.b0 = model[v.ry]; end
            OP_MVI: begin e.val = v.d;         e.lat = 1; e.b0 = v.d;         end
            OP_ADD: begin
                e.val = model[v.rx] + model[v.ry]; e.lat = 3;
                e.b0 = model[v.rx]; e.b1 = model[v.ry]; e.b2 = e.val;
            end
            default: begin
                e.val = model[v.rx] - model[v.ry]; e.lat = 3;
                e.b0 = model[v.rx]; e.b1 = model[v.ry]; e.b2 = e.val;
            end
        endcase
        model[v.rx] = e.val;
        sbQ.push_back(e);

        run   = 1'b1;
        instr = {v.op, v.rx, v.ry};
        din   = v.d;
        @(posedge clk); #1;
        run = v.noise;
        if (v.noise) instr = ~instr;
        latency = 0;
        sawDone = 1'b0;
        busLog.delete();
        while (!sawDone && latency < 8) begin
            @(negedge clk);
            latency++;
            busLog.push_back(bus);
            if (done) sawDone = 1'b1;
            @(posedge clk); #1;
            if (v.noise && !sawDone) begin
                run   = 1'($urandom_range(0, 1));
                instr = 6'($urandom);
            end
        end
        run = 1'b0;
    endtask

    // Pop the scoreboard entry for the instruction just finished and compare.
    task automatic verifyInstr(input string tag, input logic [W-1:0] tableVal);
        sb_t e;
        e = sbQ.pop_front();
        checkOutput({tag, " done seen"}, 32'(sawDone), 32'd1);
        checkOutput({tag, " latency"}, 32'(latency), 32'(e.lat));
        checkOutput({tag, " rx value"}, 32'(getReg(e.rx)), 32'(e.val));
        checkOutput({tag, " table value"}, 32'(getReg(e.rx)), 32'(tableVal));
        if (busLog.size() >= 1) checkOutput({tag, " bus c1"}, 32'(busLog[0]), 32'(e.b0));
        if (e.lat == 3 && busLog.size() >= 3) begin
            checkOutput({tag, " bus c2"}, 32'(busLog[1]), 32'(e.b1));
            checkOutput({tag, " bus c3"}, 32'(busLog[2]), 32'(e.b2));
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s r%0d", tag, i), 32'(getReg(2'(i))), 32'(model[i]));
        end
    endtask

    initial begin
        vecs[0]  = '{OP_MVI, 2'd1, 2'd0, 16'h1234, 16'h1234, 1'b0};
        vecs[1]  = '{OP_MV,  2'd3, 2'd1, 16'h0000, 16'h1234, 1'b0};
        vecs[2]  = '{OP_MVI, 2'd0, 2'd0, 16'h0005, 16'h0005, 1'b0};
        vecs[3]  = '{OP_MVI, 2'd2, 2'd0, 16'h0003, 16'h0003, 1'b0};
        vecs[4]  = '{OP_ADD, 2'd0, 2'd2, 16'h0000, 16'h0008, 1'b0};
        vecs[5]  = '{OP_MVI, 2'd1, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[6]  = '{OP_MVI, 2'd2, 2'd0, 16'h0001, 16'h0001, 1'b0};
        vecs[7]  = '{OP_SUB, 2'd1, 2'd2, 16'h0000, 16'hFFFF, 1'b0};
        vecs[8]  = '{OP_MVI, 2'd3, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[9]  = '{OP_MVI, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0};
        vecs[10] = '{OP_ADD, 2'd3, 2'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{OP_MVI, 2'd2, 2'd0, 16'h0004, 16'h0004, 1'b0};
        vecs[12] = '{OP_ADD, 2'd2, 2'd2, 16'h0000, 16'h0008, 1'b1};
        vecs[13] = '{OP_SUB, 2'd1, 2'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[14] = '{OP_MV,  2'd2, 2'd2, 16'h0000, 16'h0008, 1'b1};

        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset asserted mid-cycle, released on a falling edge.
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset r0", 32'(r0_q), 32'd0);
        checkOutput("reset r1", 32'(r1_q), 32'd0);
        checkOutput("reset r2", 32'(r2_q), 32'd0);
        checkOutput("reset r3", 32'(r3_q), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset bus", 32'(bus), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle done c%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("idle bus c%0d", c), 32'(bus), 32'd0);
        end
        @(posedge clk); #1;

        // Table-driven instruction sequence.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            verifyInstr($sformatf("vec%0d", i), vecs[i].expVal);
            if (vecs[i].noise) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checkOutput($sformatf("vec%0d no restart done c%0d", i, c), 32'(done), 32'd0);
                    checkOutput($sformatf("vec%0d no restart bus c%0d", i, c), 32'(bus), 32'd0);
                end
                @(posedge clk); #1;
            end
        end

        // Reset during T2 of an add: no partial write, no done pulse.
        applyStimulus('{OP_MVI, 2'd0, 2'd0, 16'h0007, 16'h0007, 1'b0});
        verifyInstr("pre-abort r0", 16'h0007);
        applyStimulus('{OP_MVI, 2'd1, 2'd0, 16'h0002, 16'h0002, 1'b0});
        verifyInstr("pre-abort r1", 16'h0002);
        run   = 1'b1;
        instr = {OP_ADD, 2'd0, 2'd1};
        @(posedge clk); #1;
        run = 1'b0;
        @(negedge clk);
        checkOutput("abort T1 bus", 32'(bus), 32'h0007);
        checkOutput("abort T1 done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("abort T2 bus", 32'(bus), 32'h0002);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        checkOutput("abort r0", 32'(r0_q), 32'd0);
        checkOutput("abort r1", 32'(r1_q), 32'd0);
        checkOutput("abort r2", 32'(r2_q), 32'd0);
        checkOutput("abort r3", 32'(r3_q), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort bus", 32'(bus), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-abort done c%0d", c), 32'(done), 32'd0);
            checkOutput($sformatf("post-abort r0 c%0d", c), 32'(r0_q), 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus('{OP_MVI, 2'd1, 2'd0, 16'h00AA, 16'h00AA, 1'b0});
        verifyInstr("after-abort mvi", 16'h00AA);
        applyStimulus('{OP_ADD, 2'd1, 2'd1, 16'h0000, 16'h0154, 1'b0});
        verifyInstr("after-abort add", 16'h0154);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
